// File: rtl/axil_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// axil_master_ctrl_if : core request/response port plus AXI4-Lite master bus
// Rev 1.0
// ============================================================================
interface axil_master_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_wstrb;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] M_AWADDR;
  logic [2:0]            M_AWPROT;
  logic                  M_AWVALID;
  logic                  M_AWREADY;
  logic [DATA_WIDTH-1:0] M_WDATA;
  logic [STRB_WIDTH-1:0] M_WSTRB;
  logic                  M_WVALID;
  logic                  M_WREADY;
  logic [1:0]            M_BRESP;
  logic                  M_BVALID;
  logic                  M_BREADY;
  logic [ADDR_WIDTH-1:0] M_ARADDR;
  logic [2:0]            M_ARPROT;
  logic                  M_ARVALID;
  logic                  M_ARREADY;
  logic [DATA_WIDTH-1:0] M_RDATA;
  logic [1:0]            M_RRESP;
  logic                  M_RVALID;
  logic                  M_RREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output M_AWADDR, M_AWPROT, M_AWVALID, input M_AWREADY,
    output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
    input  M_BRESP, M_BVALID, output M_BREADY,
    output M_ARADDR, M_ARPROT, M_ARVALID, input M_ARREADY,
    input  M_RDATA, M_RRESP, M_RVALID, output M_RREADY
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  M_AWADDR, M_AWPROT, M_AWVALID, output M_AWREADY,
    input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
    output M_BRESP, M_BVALID, input M_BREADY,
    input  M_ARADDR, M_ARPROT, M_ARVALID, output M_ARREADY,
    output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axil_master_ctrl.sv
`default_nettype none
// ============================================================================
// axil_master_ctrl : single-outstanding AXI4-Lite master with timeout watchdog
// Rev 1.0
// ============================================================================
module axil_master_ctrl #(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         DATA_WIDTH     = 32,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [2:0] PROT_VALUE     = 3'b000
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axil_master_ctrl_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic aw_valid, w_valid, wd_fire;

  // VALID/READY are pure decodes of registered state, so reset clears them at once
  assign aw_valid = (state_q == WR_REQ) && !aw_done_q;
  assign w_valid  = (state_q == WR_REQ) && !w_done_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_valid_d   = 1'b0;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    wd_fire       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d    = bus.req_addr;
          wdata_d   = bus.req_wdata;
          wstrb_d   = bus.req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.req_write ? WR_REQ : RD_ADDR;
        end
      end
      WR_REQ: begin
        if (aw_valid && bus.M_AWREADY) aw_done_d = 1'b1;
        if (w_valid && bus.M_WREADY)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)     state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (bus.M_BVALID) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = bus.M_BRESP;
          rsp_timeout_d = 1'b0;
        end
      end
      RD_ADDR: begin
        if (bus.M_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus.M_RVALID) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = bus.M_RRESP;
          rsp_rdata_d   = bus.M_RDATA;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A terminating handshake changes state, so it takes priority over the watchdog
    if ((TIMEOUT_CYCLES != 0) && (state_q != IDLE) && (state_d == state_q) &&
        (cnt_q == CNT_LAST)) begin
      wd_fire       = 1'b1;
      state_d       = IDLE;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end

    if ((state_q == IDLE) || (state_d != state_q)) cnt_d = '0;
    else                                           cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_resp_q    <= 2'b00;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_resp    = rsp_resp_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  assign bus.M_AWADDR  = addr_q;
  assign bus.M_AWPROT  = PROT_VALUE;
  assign bus.M_AWVALID = aw_valid;
  assign bus.M_WDATA   = wdata_q;
  assign bus.M_WSTRB   = wstrb_q;
  assign bus.M_WVALID  = w_valid;
  assign bus.M_BREADY  = (state_q == WR_RESP);
  assign bus.M_ARADDR  = addr_q;
  assign bus.M_ARPROT  = PROT_VALUE;
  assign bus.M_ARVALID = (state_q == RD_ADDR);
  assign bus.M_RREADY  = (state_q == RD_DATA);

  logic unused_ok;
  assign unused_ok = wd_fire;
endmodule
`default_nettype wire

// File: tb/tb_axil_master_ctrl.sv
`default_nettype none
// ============================================================================
// tb_axil_master_ctrl : directed bench for axil_master_ctrl (TIMEOUT_CYCLES=8)
// Rev 1.0
// ============================================================================
module tb_axil_master_ctrl;
  logic clk  = 1'b0;
  logic arst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axil_master_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_master_ctrl #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8),
    .PROT_VALUE    (3'b010)
  ) dut (
    .ACLK  (clk),
    .ARESET(arst),
    .bus   (bus)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    bus.M_AWREADY = 1'b0;
    bus.M_WREADY  = 1'b0;
    bus.M_BVALID  = 1'b0;
    bus.M_BRESP   = 2'b00;
    bus.M_ARREADY = 1'b0;
    bus.M_RVALID  = 1'b0;
    bus.M_RDATA   = 32'h0;
    bus.M_RRESP   = 2'b00;
  endtask

  task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_wstrb = 4'h0;
    slave_idle();

    // reset state
    smp();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_awvalid", bus.M_AWVALID, 0);
    chk("rst_wvalid", bus.M_WVALID, 0);
    chk("rst_arvalid", bus.M_ARVALID, 0);
    chk("rst_bready", bus.M_BREADY, 0);
    chk("rst_rready", bus.M_RREADY, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_resp", bus.rsp_resp, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    nxt();
    arst = 1'b0;

    // zero-wait write, OKAY
    req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    bus.M_AWREADY = 1'b1; bus.M_WREADY = 1'b1; bus.M_BVALID = 1'b1; bus.M_BRESP = 2'b00;
    smp(); chk("t1_c0_req_ready", bus.req_ready, 1);
    nxt(); bus.req_valid = 1'b0;
    smp();
    chk("t1_c1_awvalid", bus.M_AWVALID, 1);
    chk("t1_c1_wvalid", bus.M_WVALID, 1);
    chk("t1_c1_awaddr", bus.M_AWADDR, 32'h0000_1000);
    chk("t1_c1_wdata", bus.M_WDATA, 32'hDEAD_BEEF);
    chk("t1_c1_wstrb", bus.M_WSTRB, 4'hF);
    chk("t1_c1_awprot", bus.M_AWPROT, 3'b010);
    chk("t1_c1_bready", bus.M_BREADY, 0);
    chk("t1_c1_req_ready", bus.req_ready, 0);
    nxt(); smp();
    chk("t1_c2_bready", bus.M_BREADY, 1);
    chk("t1_c2_awvalid", bus.M_AWVALID, 0);
    chk("t1_c2_wvalid", bus.M_WVALID, 0);
    chk("t1_c2_rsp_valid", bus.rsp_valid, 0);
    nxt(); smp();
    chk("t1_c3_rsp_valid", bus.rsp_valid, 1);
    chk("t1_c3_rsp_resp", bus.rsp_resp, 2'b00);
    chk("t1_c3_rsp_timeout", bus.rsp_timeout, 0);
    chk("t1_c3_req_ready", bus.req_ready, 1);
    nxt(); slave_idle();
    smp(); chk("t1_c4_rsp_valid", bus.rsp_valid, 0);

    // write: AW accepted at cycle 1, W at cycle 4, EXOKAY
    nxt(); req(1'b1, 32'h0000_2000, 32'hA5A5_0F0F, 4'b0011);
    smp();
    nxt(); bus.req_valid = 1'b0; bus.M_AWREADY = 1'b1;
    smp();
    chk("t2_c1_awvalid", bus.M_AWVALID, 1);
    chk("t2_c1_wvalid", bus.M_WVALID, 1);
    chk("t2_c1_wstrb", bus.M_WSTRB, 4'b0011);
    chk("t2_c1_awaddr", bus.M_AWADDR, 32'h0000_2000);
    nxt(); bus.M_AWREADY = 1'b0;
    smp();
    chk("t2_c2_awvalid", bus.M_AWVALID, 0);
    chk("t2_c2_wvalid", bus.M_WVALID, 1);
    chk("t2_c2_bready", bus.M_BREADY, 0);
    nxt(); smp();
    chk("t2_c3_wvalid", bus.M_WVALID, 1);
    nxt(); bus.M_WREADY = 1'b1;
    smp();
    chk("t2_c4_wvalid", bus.M_WVALID, 1);
    chk("t2_c4_bready", bus.M_BREADY, 0);
    nxt(); bus.M_WREADY = 1'b0; bus.M_BVALID = 1'b1; bus.M_BRESP = 2'b01;
    smp();
    chk("t2_c5_wvalid", bus.M_WVALID, 0);
    chk("t2_c5_bready", bus.M_BREADY, 1);
    nxt(); bus.M_BVALID = 1'b0;
    smp();
    chk("t2_c6_rsp_valid", bus.rsp_valid, 1);
    chk("t2_c6_rsp_resp", bus.rsp_resp, 2'b01);
    chk("t2_c6_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("t2_c6_rsp_timeout", bus.rsp_timeout, 0);

    // read with 2 AR wait cycles, SLVERR
    nxt(); req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    smp();
    nxt(); bus.req_valid = 1'b0;
    smp();
    chk("t3_c1_arvalid", bus.M_ARVALID, 1);
    chk("t3_c1_rready", bus.M_RREADY, 0);
    chk("t3_c1_araddr", bus.M_ARADDR, 32'h0000_0040);
    chk("t3_c1_arprot", bus.M_ARPROT, 3'b010);
    nxt(); smp();
    chk("t3_c2_arvalid", bus.M_ARVALID, 1);
    chk("t3_c2_rready", bus.M_RREADY, 0);
    nxt(); bus.M_ARREADY = 1'b1;
    smp();
    chk("t3_c3_arvalid", bus.M_ARVALID, 1);
    chk("t3_c3_rready", bus.M_RREADY, 0);
    nxt(); bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b1;
    bus.M_RDATA = 32'h1234_5678; bus.M_RRESP = 2'b10;
    smp();
    chk("t3_c4_arvalid", bus.M_ARVALID, 0);
    chk("t3_c4_rready", bus.M_RREADY, 1);
    nxt(); bus.M_RVALID = 1'b0;
    smp();
    chk("t3_c5_rsp_valid", bus.rsp_valid, 1);
    chk("t3_c5_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("t3_c5_rsp_resp", bus.rsp_resp, 2'b10);
    chk("t3_c5_rsp_timeout", bus.rsp_timeout, 0);
    nxt(); smp();
    chk("t3_c6_rsp_valid", bus.rsp_valid, 0);
    chk("t3_c6_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);

    // read timeout: ARREADY never asserts
    nxt(); req(1'b0, 32'h0000_0080, 32'h0, 4'h0);
    smp();
    nxt(); bus.req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      smp();
      chk($sformatf("t4_c%0d_arvalid", i), bus.M_ARVALID, 1);
      chk($sformatf("t4_c%0d_rsp_valid", i), bus.rsp_valid, 0);
      nxt();
    end
    smp();
    chk("t4_c9_arvalid", bus.M_ARVALID, 0);
    chk("t4_c9_rsp_valid", bus.rsp_valid, 1);
    chk("t4_c9_rsp_timeout", bus.rsp_timeout, 1);
    chk("t4_c9_rsp_resp", bus.rsp_resp, 2'b10);
    chk("t4_c9_req_ready", bus.req_ready, 1);
    chk("t4_c9_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);

    // back-to-back: zero-strobe write DECERR, read accepted in rsp_valid cycle
    nxt(); req(1'b1, 32'h0000_3000, 32'h1122_3344, 4'h0);
    bus.M_AWREADY = 1'b1; bus.M_WREADY = 1'b1; bus.M_BVALID = 1'b1; bus.M_BRESP = 2'b11;
    smp();
    nxt(); bus.req_valid = 1'b0;
    smp();
    chk("t5_c1_awvalid", bus.M_AWVALID, 1);
    chk("t5_c1_wstrb", bus.M_WSTRB, 4'h0);
    nxt(); smp();
    chk("t5_c2_bready", bus.M_BREADY, 1);
    nxt(); slave_idle(); req(1'b0, 32'h0000_0044, 32'h0, 4'h0);
    smp();
    chk("t5_c3_rsp_valid", bus.rsp_valid, 1);
    chk("t5_c3_rsp_resp", bus.rsp_resp, 2'b11);
    chk("t5_c3_rsp_timeout", bus.rsp_timeout, 0);
    chk("t5_c3_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("t5_c3_req_ready", bus.req_ready, 1);
    nxt(); bus.req_valid = 1'b0; bus.M_ARREADY = 1'b1;
    smp();
    chk("t5_c4_arvalid", bus.M_ARVALID, 1);
    chk("t5_c4_araddr", bus.M_ARADDR, 32'h0000_0044);
    chk("t5_c4_rsp_valid", bus.rsp_valid, 0);
    nxt(); bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b1;
    bus.M_RDATA = 32'hCAFE_F00D; bus.M_RRESP = 2'b00;
    smp();
    chk("t5_c5_rready", bus.M_RREADY, 1);
    nxt(); bus.M_RVALID = 1'b0;
    smp();
    chk("t5_c6_rsp_valid", bus.rsp_valid, 1);
    chk("t5_c6_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    chk("t5_c6_rsp_resp", bus.rsp_resp, 2'b00);

    // asynchronous reset in the middle of WR_REQ
    nxt(); slave_idle(); req(1'b1, 32'h0000_4000, 32'h5555_AAAA, 4'hF);
    smp();
    nxt(); bus.req_valid = 1'b0;
    smp();
    chk("t6_c1_awvalid", bus.M_AWVALID, 1);
    chk("t6_c1_wvalid", bus.M_WVALID, 1);
    #2 arst = 1'b1;
    #1;
    chk("t6_arst_awvalid", bus.M_AWVALID, 0);
    chk("t6_arst_wvalid", bus.M_WVALID, 0);
    chk("t6_arst_bready", bus.M_BREADY, 0);
    chk("t6_arst_arvalid", bus.M_ARVALID, 0);
    chk("t6_arst_req_ready", bus.req_ready, 1);
    chk("t6_arst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("t6_arst_awaddr", bus.M_AWADDR, 32'h0);
    nxt(); nxt(); arst = 1'b0;
    smp();
    chk("t6_post_req_ready", bus.req_ready, 1);
    chk("t6_post_awvalid", bus.M_AWVALID, 0);
    chk("t6_post_rsp_valid", bus.rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axil_master_ctrl.md
Name: axil_master_ctrl

Overview:
Parametrised AXI4-Lite master that turns single-beat read/write requests from a core-side valid/ready port into AXI4-Lite transactions. It is the next generation of the CPU data-memory bus master. Compared with the previous master it adds:
- decoupled AW/W handshakes
- byte strobes
- captured read data
- full response-code reporting (SLVERR/DECERR complete, no stall)
- a per-transaction timeout watchdog

It sits between the load/store unit and the AXI4-Lite interconnect.

Parameters:
ADDR_WIDTH, 32, address width of req_addr and M_AWADDR/M_ARADDR
DATA_WIDTH, 32, data width; must be 32 or 64; STRB_WIDTH = DATA_WIDTH/8
TIMEOUT_CYCLES, 1024, cycles allowed in any non-IDLE state before abort; 0 disables watchdog
PROT_VALUE, 3'b000, constant driven on M_AWPROT/M_ARPROT

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block accepts request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  STRB_WIDTH  write byte enables
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data (valid with rsp_valid on reads)
rsp_resp  out  2  AXI response code of completed transfer
rsp_timeout  out  1  completion caused by watchdog
M_AWADDR, M_AWPROT(3), M_AWVALID out; M_AWREADY in
M_WDATA, M_WSTRB(STRB_WIDTH), M_WVALID out; M_WREADY in
M_BRESP(2), M_BVALID in; M_BREADY out
M_ARADDR, M_ARPROT(3), M_ARVALID out; M_ARREADY in
M_RDATA(DATA_WIDTH), M_RRESP(2), M_RVALID in; M_RREADY out

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA. One transaction outstanding at a time.
- Reset (async, immediate): state=IDLE; all VALID/READY outputs 0; rsp_valid=0; rsp_timeout=0; rsp_resp=0; rsp_rdata=0; address/data/strobe registers 0; timeout counter 0.
- req_ready = (state==IDLE), combinational from state.
- Accept on req_valid&&req_ready. addr, wdata, wstrb and write are registered at acceptance. AXI address/data outputs are driven from these registers and hold stable until handshake.
- IDLE -> WR_REQ (write) or RD_ADDR (read). M_AWVALID, M_WVALID or M_ARVALID are registered and rise the cycle after acceptance.
- WR_REQ:
  - aw_done and w_done flags track the two handshakes independently.
  - M_AWVALID drops the cycle after AWVALID&&AWREADY; M_WVALID drops the cycle after WVALID&&WREADY. Either order, or the same cycle, is legal.
  - When both are done (including the same-cycle case), go to WR_RESP.
- WR_RESP: M_BREADY=1. On BVALID, capture BRESP and go to IDLE.
- RD_ADDR: M_ARVALID=1. On ARREADY, go to RD_DATA. M_RREADY=0 in RD_ADDR.
- RD_DATA: M_RREADY=1. On RVALID, capture RDATA and RRESP, and go to IDLE.
- Completion:
  - rsp_valid pulses high for exactly one cycle, the cycle after the B or R handshake.
  - rsp_resp and rsp_rdata are registered and hold until the next completion.
  - Any response code completes; OKAY/EXOKAY/SLVERR/DECERR are all reported verbatim.
  - On writes, rsp_rdata is unchanged.
- Best-case latency, zero-wait slave: request accepted at cycle 0; VALID at cycle 1; B/R handshake at cycle 2; rsp_valid at cycle 3. A new request can be accepted in the rsp_valid cycle.
- Watchdog:
  - The counter clears on entry to any non-IDLE state and increments each cycle in non-IDLE states.
  - When count == TIMEOUT_CYCLES-1 with no terminating handshake, the block deasserts all AXI VALID/READY, returns to IDLE, and pulses rsp_valid with rsp_timeout=1 and rsp_resp=2'b10.
  - A handshake in the terminal cycle wins over the timeout.
  - rsp_timeout=0 on normal completion.
- req_* inputs are ignored while not IDLE.
- req_wstrb=0 is legal and is issued unchanged.

Test Plan:
- Write 0x0000_1000/0xDEAD_BEEF/strb 4'hF, zero-wait slave with BRESP=00 -> AWVALID and WVALID at cycle 1, BREADY at cycle 2, rsp_valid at cycle 3 with rsp_resp=00 and rsp_timeout=0.
- Write with AWREADY at cycle 1 and WREADY delayed to cycle 4 -> AWVALID low from cycle 2, WVALID held through cycle 4, WR_RESP entered at cycle 5; WSTRB 4'b0011 seen on the bus.
- Read 0x0000_0040, ARREADY after 2 waits, RVALID with RDATA=0x1234_5678 and RRESP=10 -> RREADY low during RD_ADDR, one-cycle rsp_valid with rsp_rdata=0x1234_5678 and rsp_resp=10.
- TIMEOUT_CYCLES=8, read where ARREADY never asserts -> ARVALID drops after 8 cycles in RD_ADDR; rsp_valid with rsp_timeout=1 and rsp_resp=10; req_ready high the following cycle.
- Back-to-back: new read request held during the rsp_valid cycle of a write -> accepted in that same cycle, ARVALID the next cycle.
- Assert ARESET asynchronously mid WR_REQ -> all VALIDs and BREADY go 0 without a clock edge; after release, state is IDLE and req_ready=1.
